// File: rtl/hazard_pkg.sv
// Shared types and defaults for the hazard scoreboard unit.
// Holds the forwarding select encoding and default widths.
package hazard_pkg;

  localparam int HAZ_AW    = 5;
  localparam int HAZ_CNT_W = 32;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  // MEM wins over WB when both hold the operand.
  function automatic fwd_sel_e fwd_pick(
    input logic hit_m,
    input logic hit_w
  );
    unique case (1'b1)
      hit_m:   return FWD_M;
      hit_w:   return FWD_W;
      default: return FWD_RF;
    endcase
  endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// Pipeline-side bundle for the hazard scoreboard unit.
// master = datapath side, slave = hazard unit side.
interface hazard_scoreboard_unit_if
  import hazard_pkg::*;
#(
  parameter int AW    = HAZ_AW,
  parameter int CNT_W = HAZ_CNT_W
) ();

  logic [AW-1:0]    Rs1D, Rs2D, RdD;
  logic             RegWriteD, LongOpD;
  logic [AW-1:0]    Rs1E, Rs2E, RdE;
  logic             MemReadE, LongOpE, PCSrcE;
  logic [AW-1:0]    RdM, RdW;
  logic             RegWriteM, RegWriteW;

  logic             StallF, StallD;
  logic             FlushD, FlushE;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             LongBusy;
  logic [AW-1:0]    LongRd;
  logic             LongDone;
  logic [CNT_W-1:0] StallCnt, FlushCnt, LongCnt;

  modport master (
    output Rs1D, Rs2D, RdD, RegWriteD, LongOpD,
    output Rs1E, Rs2E, RdE, MemReadE, LongOpE, PCSrcE,
    output RdM, RegWriteM, RdW, RegWriteW,
    input  StallF, StallD, FlushD, FlushE,
    input  ForwardAE, ForwardBE,
    input  LongBusy, LongRd, LongDone,
    input  StallCnt, FlushCnt, LongCnt
  );

  modport slave (
    input  Rs1D, Rs2D, RdD, RegWriteD, LongOpD,
    input  Rs1E, Rs2E, RdE, MemReadE, LongOpE, PCSrcE,
    input  RdM, RegWriteM, RdW, RegWriteW,
    output StallF, StallD, FlushD, FlushE,
    output ForwardAE, ForwardBE,
    output LongBusy, LongRd, LongDone,
    output StallCnt, FlushCnt, LongCnt
  );

endinterface

// File: rtl/hazard_scoreboard_unit_long_op_tracker.sv
// Single-entry scoreboard for one in-flight MUL/DIV op.
// Done pulses in the last busy cycle; reset drops the op.
module long_op_tracker
  import hazard_pkg::*;
#(
  parameter int AW     = HAZ_AW,
  parameter int MD_LAT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_issue,
  input  logic          i_long_op,
  input  logic [AW-1:0] i_rd,
  output logic          o_busy,
  output logic [AW-1:0] o_rd,
  output logic          o_done
);

  localparam int CW = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;

  logic          r_busy;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_rd;
  logic          w_done;

  assign w_done = r_busy && (r_cnt == '0);

  // Accept an issue when idle, count down, retire on done.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_rd   <= '0;
    end else if (!r_busy) begin
      if (i_issue) begin
        r_busy <= 1'b1;
        r_rd   <= i_rd;
        r_cnt  <= CW'(MD_LAT - 1);
      end
    end else if (w_done) begin
      r_busy <= 1'b0;
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_busy = r_busy;
  assign o_rd   = r_rd;
  assign o_done = w_done;

  a_no_issue_busy: assert property (
    @(posedge clk) disable iff (reset)
    !(r_busy && i_long_op)
  ) else $error("long op issued while tracker busy");

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Hazard control for the 5-stage pipe: forwarding, load-use,
// long-op scoreboard, branch flush. Counters: HAZ_PERF_CNT_EN.
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int AW       = HAZ_AW,
  parameter int LOAD_LAT = 1,
  parameter int MD_LAT   = 4,
  parameter int CNT_W    = HAZ_CNT_W
) (
  input  logic                    clk,
  input  logic                    reset,
  hazard_scoreboard_unit_if.slave bus
);

  localparam int LUW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

  logic           w_hit_ma, w_hit_wa;
  logic           w_hit_mb, w_hit_wb;
  fwd_sel_e       w_fwd_a, w_fwd_b;
  logic           w_lu_hit, w_lu_act;
  logic [LUW-1:0] r_lu_cnt;
  logic           w_busy, w_done;
  logic [AW-1:0]  w_long_rd;
  logic           w_lrd_nz;
  logic           w_raw, w_waw;
  logic           w_long_stall;
  logic           w_stall;
  logic           w_stall_fd;
  logic           w_flush_e;
  logic           w_issue;

  assign w_hit_ma = bus.RegWriteM && (bus.RdM != '0)
                 && (bus.RdM == bus.Rs1E);
  assign w_hit_wa = bus.RegWriteW && (bus.RdW != '0)
                 && (bus.RdW == bus.Rs1E);
  assign w_hit_mb = bus.RegWriteM && (bus.RdM != '0)
                 && (bus.RdM == bus.Rs2E);
  assign w_hit_wb = bus.RegWriteW && (bus.RdW != '0)
                 && (bus.RdW == bus.Rs2E);

  // Pick EX operand sources, MEM before WB.
  always_comb begin
    w_fwd_a = fwd_pick(w_hit_ma, w_hit_wa);
    w_fwd_b = fwd_pick(w_hit_mb, w_hit_wb);
  end

  assign w_lu_hit = bus.MemReadE && (bus.RdE != '0)
                 && ((bus.RdE == bus.Rs1D)
                  || (bus.RdE == bus.Rs2D));
  assign w_lu_act = r_lu_cnt != '0;

  // Count the extra load-use bubbles; a branch cancels them.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lu_cnt <= '0;
    end else if (bus.PCSrcE) begin
      r_lu_cnt <= '0;
    end else if (w_lu_act) begin
      r_lu_cnt <= r_lu_cnt - 1'b1;
    end else if (w_lu_hit) begin
      r_lu_cnt <= LUW'(LOAD_LAT - 1);
    end
  end

  assign w_lrd_nz = w_long_rd != '0;
  assign w_raw = w_lrd_nz
              && ((bus.Rs1D == w_long_rd)
               || (bus.Rs2D == w_long_rd));
  assign w_waw = w_lrd_nz && bus.RegWriteD
              && (bus.RdD == w_long_rd);
  assign w_long_stall = w_busy
                     && (w_raw || w_waw || bus.LongOpD);

  assign w_stall    = w_lu_hit || w_lu_act || w_long_stall;
  assign w_stall_fd = w_stall && !bus.PCSrcE;
  assign w_flush_e  = w_stall || bus.PCSrcE;
  assign w_issue    = bus.LongOpE && !w_flush_e;

  long_op_tracker #(
    .AW     (AW),
    .MD_LAT (MD_LAT)
  ) u_long (
    .clk       (clk),
    .reset     (reset),
    .i_issue   (w_issue),
    .i_long_op (bus.LongOpE),
    .i_rd      (bus.RdE),
    .o_busy    (w_busy),
    .o_rd      (w_long_rd),
    .o_done    (w_done)
  );

  assign bus.StallF    = w_stall_fd;
  assign bus.StallD    = w_stall_fd;
  assign bus.FlushD    = bus.PCSrcE;
  assign bus.FlushE    = w_flush_e;
  assign bus.ForwardAE = w_fwd_a;
  assign bus.ForwardBE = w_fwd_b;
  assign bus.LongBusy  = w_busy;
  assign bus.LongRd    = w_long_rd;
  assign bus.LongDone  = w_done;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt, r_long_cnt;
  logic             w_accept;

  assign w_accept = w_issue && !w_busy;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_long_cnt  <= '0;
    end else begin
      if (w_stall_fd && !(&r_stall_cnt))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (bus.PCSrcE && !(&r_flush_cnt))
        r_flush_cnt <= r_flush_cnt + 1'b1;
      if (w_accept && !(&r_long_cnt))
        r_long_cnt <= r_long_cnt + 1'b1;
    end
  end

  assign bus.StallCnt = r_stall_cnt;
  assign bus.FlushCnt = r_flush_cnt;
  assign bus.LongCnt  = r_long_cnt;
`else
  assign bus.StallCnt = '0;
  assign bus.FlushCnt = '0;
  assign bus.LongCnt  = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit: directed cases, then
// random traffic against a cycle-indexed reference model.
module tb_hazard_scoreboard_unit;
  import hazard_pkg::*;

  localparam int AW       = 5;
  localparam int LOAD_LAT = 2;
  localparam int MD_LAT   = 4;
  localparam int CNT_W    = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_scoreboard_unit_if #(.AW(AW), .CNT_W(CNT_W)) bus ();

  hazard_scoreboard_unit #(
    .AW       (AW),
    .LOAD_LAT (LOAD_LAT),
    .MD_LAT   (MD_LAT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // model: op issued in cycle iss is busy in cycles iss+1..iss+MD_LAT
  int               cyc     = 0;
  int               iss     = -1000;
  int               lu_owed = 0;
  logic [AW-1:0]    m_rd    = '0;
  logic [CNT_W-1:0] m_sc    = '0;
  logic [CNT_W-1:0] m_fc    = '0;
  logic [CNT_W-1:0] m_lc    = '0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_busy();
    int d = cyc - iss;
    return (d >= 1) && (d <= MD_LAT);
  endfunction

  function automatic logic [1:0] m_fwd(input logic [AW-1:0] rs);
    if (bus.RegWriteM && bus.RdM != 0 && bus.RdM == rs) return 2'b10;
    if (bus.RegWriteW && bus.RdW != 0 && bus.RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1;
  endfunction

  task automatic idle();
    bus.Rs1D = '0; bus.Rs2D = '0; bus.RdD = '0;
    bus.RegWriteD = 1'b0; bus.LongOpD = 1'b0;
    bus.Rs1E = '0; bus.Rs2E = '0; bus.RdE = '0;
    bus.MemReadE = 1'b0; bus.LongOpE = 1'b0; bus.PCSrcE = 1'b0;
    bus.RdM = '0; bus.RegWriteM = 1'b0;
    bus.RdW = '0; bus.RegWriteW = 1'b0;
  endtask

  // check every output for this cycle, clock, then advance the model
  task automatic cycle();
    bit lu_hit, busy, done, lst, st, st_fd, fl_e, rst, lop, pc;
    logic [AW-1:0] rde;
    #1;
    busy = m_busy();
    done = busy && (cyc - iss == MD_LAT);
    lu_hit = bus.MemReadE && bus.RdE != 0
          && (bus.RdE == bus.Rs1D || bus.RdE == bus.Rs2D);
    lst = busy && (bus.LongOpD || (m_rd != 0 &&
          (bus.Rs1D == m_rd || bus.Rs2D == m_rd ||
           (bus.RegWriteD && bus.RdD == m_rd))));
    st    = lu_hit || lu_owed > 0 || lst;
    pc    = bus.PCSrcE;
    st_fd = st && !pc;
    fl_e  = st || pc;
    chk("StallF",    bus.StallF,    st_fd);
    chk("StallD",    bus.StallD,    st_fd);
    chk("FlushD",    bus.FlushD,    pc);
    chk("FlushE",    bus.FlushE,    fl_e);
    chk("ForwardAE", bus.ForwardAE, m_fwd(bus.Rs1E));
    chk("ForwardBE", bus.ForwardBE, m_fwd(bus.Rs2E));
    chk("LongBusy",  bus.LongBusy,  busy);
    chk("LongRd",    bus.LongRd,    m_rd);
    chk("LongDone",  bus.LongDone,  done);
`ifdef HAZ_PERF_CNT_EN
    chk("StallCnt",  bus.StallCnt,  m_sc);
    chk("FlushCnt",  bus.FlushCnt,  m_fc);
    chk("LongCnt",   bus.LongCnt,   m_lc);
`else
    chk("StallCnt",  bus.StallCnt,  '0);
    chk("FlushCnt",  bus.FlushCnt,  '0);
    chk("LongCnt",   bus.LongCnt,   '0);
`endif
    rst = reset;
    lop = bus.LongOpE;
    rde = bus.RdE;
    @(posedge clk);
    if (rst) begin
      iss = -1000; lu_owed = 0; m_rd = '0;
      m_sc = '0; m_fc = '0; m_lc = '0;
    end else begin
      if (lop && !fl_e && !busy) begin
        iss  = cyc;
        m_rd = rde;
        m_lc = sat_inc(m_lc);
      end
      if (st_fd) m_sc = sat_inc(m_sc);
      if (pc)    m_fc = sat_inc(m_fc);
      if (pc)               lu_owed = 0;
      else if (lu_owed > 0) lu_owed = lu_owed - 1;
      else if (lu_hit)      lu_owed = LOAD_LAT - 1;
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;

    // state right after reset
    #1;
    chk("rst_stall",   bus.StallD,   1'b0);
    chk("rst_flushE",  bus.FlushE,   1'b0);
    chk("rst_busy",    bus.LongBusy, 1'b0);
    chk("rst_longrd",  bus.LongRd,   '0);
    chk("rst_stallcnt", bus.StallCnt, '0);
    cycle();

    // forwarding priority
    bus.Rs1E = 5; bus.RegWriteM = 1; bus.RdM = 5;
    bus.RegWriteW = 1; bus.RdW = 5;
    #1 chk("fwdA_M", bus.ForwardAE, 2'b10);
    cycle();
    bus.RegWriteM = 0;
    #1 chk("fwdA_W", bus.ForwardAE, 2'b01);
    cycle();
    bus.RegWriteM = 1; bus.RdM = 0; bus.RegWriteW = 0;
    #1 chk("fwdA_x0", bus.ForwardAE, 2'b00);
    cycle();
    idle();
    bus.Rs2E = 5; bus.RegWriteW = 1; bus.RdW = 5;
    #1 chk("fwdB_W", bus.ForwardBE, 2'b01);
    cycle();

    // load-use: two bubbles
    idle();
    bus.MemReadE = 1; bus.RdE = 3; bus.Rs1D = 3;
    #1 chk("lu_c0_stall", bus.StallD, 1'b1);
    chk("lu_c0_flushE", bus.FlushE, 1'b1);
    cycle();
    idle(); bus.Rs1D = 3;
    #1 chk("lu_c1_stall", bus.StallF, 1'b1);
    cycle();
    #1 chk("lu_c2_release", bus.StallD, 1'b0);
    cycle();

    // mul x7 then dependent reader
    idle(); bus.LongOpE = 1; bus.RdE = 7;
    cycle();
    idle(); bus.Rs1D = 7;
    for (int k = 1; k <= MD_LAT; k++) begin
      #1 chk("mul_stall", bus.StallD, 1'b1);
      chk("mul_done", bus.LongDone, (k == MD_LAT));
      cycle();
    end
    #1 chk("mul_release", bus.StallD, 1'b0);
    chk("mul_idle", bus.LongBusy, 1'b0);
    cycle();

    // structural, WAW, unrelated
    idle(); bus.LongOpE = 1; bus.RdE = 7;
    cycle();
    idle(); bus.LongOpD = 1;
    #1 chk("struct_stall", bus.StallD, 1'b1);
    cycle();
    idle(); bus.RegWriteD = 1; bus.RdD = 7;
    #1 chk("waw_stall", bus.StallD, 1'b1);
    cycle();
    bus.RdD = 8;
    #1 chk("nohaz_stall", bus.StallD, 1'b0);
    cycle();
    idle();
    cycle();
    cycle();

    // branch over a load-use stall
    idle(); bus.MemReadE = 1; bus.RdE = 3; bus.Rs1D = 3;
    cycle();
    idle(); bus.Rs1D = 3; bus.PCSrcE = 1;
    #1 chk("br_flushD", bus.FlushD, 1'b1);
    chk("br_flushE", bus.FlushE, 1'b1);
    chk("br_stallF", bus.StallF, 1'b0);
    chk("br_stallD", bus.StallD, 1'b0);
    cycle();
    idle();
    #1 chk("br_lu_cleared", bus.StallD, 1'b0);
    cycle();

    // reset two cycles after issue
    idle(); bus.LongOpE = 1; bus.RdE = 9;
    cycle();
    idle();
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int k = 0; k < MD_LAT + 1; k++) begin
      #1 chk("rstmid_busy", bus.LongBusy, 1'b0);
      chk("rstmid_done", bus.LongDone, 1'b0);
      cycle();
    end

    // stall counter from zero
    #1 chk("cnt_zero", bus.StallCnt, '0);
    bus.MemReadE = 1; bus.RdE = 4; bus.Rs2D = 4;
    cycle();
    idle(); bus.Rs2D = 4;
    cycle();
    idle();
    #1;
`ifdef HAZ_PERF_CNT_EN
    chk("cnt_two", bus.StallCnt, 2);
`else
    chk("cnt_two", bus.StallCnt, 0);
`endif
    cycle();

    // random traffic
    for (int n = 0; n < 800; n++) begin
      reset = ($urandom_range(99) == 0);
      bus.Rs1D = AW'($urandom_range(7));
      bus.Rs2D = AW'($urandom_range(7));
      bus.RdD  = AW'($urandom_range(7));
      bus.RegWriteD = 1'($urandom_range(1));
      bus.LongOpD   = ($urandom_range(9) == 0);
      bus.Rs1E = AW'($urandom_range(7));
      bus.Rs2E = AW'($urandom_range(7));
      bus.RdE  = AW'($urandom_range(7));
      bus.MemReadE = ($urandom_range(3) == 0);
      bus.LongOpE  = !m_busy() && ($urandom_range(5) == 0);
      bus.PCSrcE   = ($urandom_range(9) == 0);
      bus.RdM = AW'($urandom_range(7));
      bus.RegWriteM = 1'($urandom_range(1));
      bus.RdW = AW'($urandom_range(7));
      bus.RegWriteW = 1'($urandom_range(1));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
